// File: rtl/lane_pkg.sv
// lane_pkg: LFSR tap table, gap-row builder and mode encodings for the lane generator
package lane_pkg;

   localparam logic MODE_RANDOM = 1'b0;
   localparam logic MODE_DRIFT  = 1'b1;

   // Maximal-length Fibonacci taps, bit i set means lfsr[i] feeds the XOR
   function automatic logic [15:0] tap_mask(input int w);
      return w == 3  ? 16'h0006 :
             w == 4  ? 16'h000C :
             w == 5  ? 16'h0014 :
             w == 6  ? 16'h0030 :
             w == 7  ? 16'h0060 :
             w == 8  ? 16'h00B8 :
             w == 9  ? 16'h0110 :
             w == 10 ? 16'h0240 :
             w == 11 ? 16'h0500 :
             w == 12 ? 16'h0829 :
             w == 13 ? 16'h100D :
             w == 14 ? 16'h2015 :
             w == 15 ? 16'h6000 : 16'hD008;
   endfunction

   function automatic logic [31:0] gap_row(input int pos, input int gap_w, input int line_w);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = (i < line_w) && !(i >= pos && i < pos + gap_w);
      return r;
   endfunction

endpackage

// File: rtl/lane_fifo.sv
// lane_fifo: small prefetch FIFO with occupancy count and synchronous flush
module lane_fifo #(
   parameter int W     = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic                       flush,
   input  logic                       push,
   input  logic                       pop,
   input  logic [W-1:0]               din,
   output logic [W-1:0]               dout,
   output logic [$clog2(DEPTH):0]     count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic          wr, rd;
   assign wr   = push && count != CW'(DEPTH);
   assign rd   = pop && count != '0;
   assign dout = mem[rp];
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else if (flush) begin
         wp    <= '0;
         rp    <= '0;
         count <= '0;
      end else begin
         wp    <= wp + AW'(wr);
         rp    <= rp + AW'(rd);
         count <= count + CW'(wr) - CW'(rd);
      end
   always_ff @(posedge clock)
      if (wr && !flush) mem[wp] <= din;
endmodule

// File: rtl/lane_pattern_gen.sv
// lane_pattern_gen: LFSR-driven single-gap lane rows, prefetched into a FIFO
// and handed out over valid/ready; random or drifting gap placement.
module lane_pattern_gen
   import lane_pkg::*;
#(
   parameter int LINE_W       = 8,
   parameter int GAP_W        = 2,
   parameter int LFSR_W       = 3,
   parameter int DEPTH        = 4,
   parameter int SEED_DEFAULT = 1
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      enable,
   input  logic                      mode,
   input  logic                      seed_load,
   input  logic [LFSR_W-1:0]         seed,
   input  logic                      row_ready,
   output logic                      row_valid,
   output logic [LINE_W-1:0]         row,
   output logic [$clog2(LINE_W)-1:0] gap_pos
);
   localparam int MAXPOS = LINE_W - GAP_W;
   localparam int RANGE  = MAXPOS + 1;
   localparam int K      = $clog2(RANGE);
   localparam int PW     = $clog2(LINE_W);
   localparam int CW     = $clog2(DEPTH) + 1;
   localparam logic [15:0]       TAP_ALL = tap_mask(LFSR_W);
   localparam logic [LFSR_W-1:0] TAPS    = TAP_ALL[LFSR_W-1:0];
   localparam logic [LFSR_W-1:0] SEED0   = LFSR_W'(SEED_DEFAULT == 0 ? 1 : SEED_DEFAULT);
   localparam logic [PW-1:0]     MAXP    = PW'(MAXPOS);
   localparam logic [PW-1:0]     MIDP    = PW'(MAXPOS / 2);
   logic [LFSR_W-1:0]    lfsr;
   logic [PW-1:0]        prev_pos, pos;
   logic [K-1:0]         c;
   logic [LINE_W-1:0]    gap;
   logic [CW-1:0]        count;
   logic [LINE_W+PW-1:0] head;
   logic                 push, pop;
   assign c   = K'(lfsr);
   // 2^K < 2*RANGE, so one subtract folds any out-of-range draw back in
   assign pos = mode == MODE_DRIFT
              ? (lfsr[0] ? (prev_pos == MAXP ? MAXP : prev_pos + 1'b1)
                         : (prev_pos == '0 ? '0 : prev_pos - 1'b1))
              : (c > K'(MAXPOS) ? PW'(c - K'(RANGE)) : PW'(c));
   assign gap       = LINE_W'(gap_row(int'(pos), GAP_W, LINE_W));
   assign push      = enable && count < CW'(DEPTH) && !seed_load;
   assign pop       = row_valid && row_ready && !seed_load;
   assign row_valid = count != '0;
   assign row       = row_valid ? head[LINE_W-1:0] : '1;
   assign gap_pos   = row_valid ? head[LINE_W+PW-1:LINE_W] : '0;
   lane_fifo #(.W(LINE_W + PW), .DEPTH(DEPTH)) u_fifo (
      .clock (clock),
      .reset (reset),
      .flush (seed_load),
      .push  (push),
      .pop   (pop),
      .din   ({pos, gap}),
      .dout  (head),
      .count (count)
   );
   always_ff @(posedge clock or negedge reset)
      if (!reset) begin
         lfsr     <= SEED0;
         prev_pos <= MIDP;
      end else if (seed_load) begin
         lfsr     <= seed == '0 ? LFSR_W'(1) : seed;
         prev_pos <= MIDP;
      end else begin
         if (push) prev_pos <= pos;
         if (lfsr == '0) lfsr <= LFSR_W'(1);
         else if (push) lfsr <= {lfsr[LFSR_W-2:0], ^(lfsr & TAPS)};
      end
endmodule

// File: tb/tb_lane_pattern_gen.sv
// tb_lane_pattern_gen: directed vector table on the default build plus a
// random-backpressure sweep of a 16-wide build against a reference model.
module tb_lane_pattern_gen;
   logic clock = 1'b0;
   logic reset = 1'b0;
   always #5 clock = ~clock;

   logic       enable = 1'b0, mode = 1'b0, seed_load = 1'b0, row_ready = 1'b0;
   logic [2:0] seed = '0;
   logic       row_valid;
   logic [7:0] row;
   logic [2:0] gap_pos;

   logic        en16 = 1'b0, rdy16 = 1'b0, sl16 = 1'b0, mode16 = 1'b0;
   logic [4:0]  seed16 = '0;
   logic        row_valid16;
   logic [15:0] row16;
   logic [3:0]  gap_pos16;

   lane_pattern_gen dut (
      .clock     (clock),
      .reset     (reset),
      .enable    (enable),
      .mode      (mode),
      .seed_load (seed_load),
      .seed      (seed),
      .row_ready (row_ready),
      .row_valid (row_valid),
      .row       (row),
      .gap_pos   (gap_pos)
   );

   lane_pattern_gen #(.LINE_W(16), .GAP_W(3), .LFSR_W(5)) dut16 (
      .clock     (clock),
      .reset     (reset),
      .enable    (en16),
      .mode      (mode16),
      .seed_load (sl16),
      .seed      (seed16),
      .row_ready (rdy16),
      .row_valid (row_valid16),
      .row       (row16),
      .gap_pos   (gap_pos16)
   );

   typedef struct {
      logic       sl;
      logic [2:0] sd;
      logic       md, en, rd, v;
      logic [7:0] r;
      logic [2:0] p;
   } vec_t;
   vec_t tv[$];

   int n_vec = 0, n_miss = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic add(input logic sl, input logic [2:0] sd, input logic md, input logic en,
                      input logic rd, input logic v, input logic [7:0] r, input logic [2:0] p);
      vec_t t;
      t.sl = sl; t.sd = sd; t.md = md; t.en = en; t.rd = rd; t.v = v; t.r = r; t.p = p;
      tv.push_back(t);
   endtask

   function automatic int zero_runs(input logic [15:0] r);
      int n = 0;
      for (int i = 0; i < 16; i++) if (!r[i] && (i == 0 || r[i-1])) n++;
      return n;
   endfunction

   logic [7:0] rr [7] = '{8'hf9, 8'hf3, 8'h9f, 8'he7, 8'hfc, 8'h3f, 8'hcf};
   logic [2:0] pp [7] = '{3'd1, 3'd2, 3'd5, 3'd3, 3'd0, 3'd6, 3'd4};
   logic [7:0] dr [7] = '{8'hcf, 8'he7, 8'hcf, 8'h9f, 8'h3f, 8'h9f, 8'hcf};
   logic [2:0] dp [7] = '{3'd4, 3'd3, 3'd4, 3'd5, 3'd6, 3'd5, 3'd4};

   initial begin
      logic [4:0]  ml;
      logic [3:0]  mc, mp;
      logic [15:0] mrow;
      int          pops;
      for (int i = 0; i < 7; i++) add(0, 0, 0, 1, 1, 1, rr[i], pp[i]);
      add(0, 0, 0, 1, 1, 1, rr[0], pp[0]);
      add(1, 1, 0, 1, 1, 0, 8'hff, 0);
      for (int i = 0; i < 7; i++) add(0, 0, 1, 1, 1, 1, dr[i], dp[i]);
      add(1, 1, 0, 1, 1, 0, 8'hff, 0);
      for (int i = 0; i < 6; i++) add(0, 0, 0, 1, 0, 1, rr[0], pp[0]);
      for (int i = 1; i < 5; i++) add(0, 0, 0, 1, 1, 1, rr[i], pp[i]);
      add(1, 0, 0, 1, 1, 0, 8'hff, 0);
      add(0, 0, 0, 1, 1, 1, rr[0], pp[0]);
      add(0, 0, 0, 1, 1, 1, rr[1], pp[1]);
      add(0, 0, 0, 0, 1, 0, 8'hff, 0);
      add(0, 0, 0, 1, 1, 1, rr[2], pp[2]);

      #2;
      check("reset valid", 32'(row_valid), 0);
      check("reset row", 32'(row), 32'hff);
      check("reset gap_pos", 32'(gap_pos), 0);
      check("reset valid16", 32'(row_valid16), 0);
      enable = 1'b1;
      row_ready = 1'b1;
      #20 reset = 1'b1;

      foreach (tv[i]) begin
         seed_load = tv[i].sl;
         seed      = tv[i].sd;
         mode      = tv[i].md;
         enable    = tv[i].en;
         row_ready = tv[i].rd;
         @(posedge clock);
         #1;
         check($sformatf("vec%0d valid", i), 32'(row_valid), 32'(tv[i].v));
         check($sformatf("vec%0d row", i), 32'(row), 32'(tv[i].r));
         check($sformatf("vec%0d gap_pos", i), 32'(gap_pos), 32'(tv[i].p));
      end

      check("pre-reset valid", 32'(row_valid), 1);
      #2 reset = 1'b0;
      #1;
      check("async reset valid", 32'(row_valid), 0);
      check("async reset row", 32'(row), 32'hff);
      check("async reset gap_pos", 32'(gap_pos), 0);
      @(negedge clock);
      reset = 1'b1;
      @(posedge clock);
      #1;
      check("restart row", 32'(row), 32'hf9);
      check("restart gap_pos", 32'(gap_pos), 1);
      enable = 1'b0;

      ml = 5'd1;
      pops = 0;
      en16 = 1'b1;
      for (int cyc = 0; cyc < 400; cyc++) begin
         @(negedge clock);
         rdy16 = 1'($urandom_range(0, 1));
         if (row_valid16 && rdy16) begin
            mc   = ml[3:0];
            mp   = mc > 4'd13 ? mc - 4'd14 : mc;
            mrow = ~(16'h0007 << mp);
            ml   = {ml[3:0], ml[4] ^ ml[2]};
            check($sformatf("sweep%0d row", pops), 32'(row16), 32'(mrow));
            check($sformatf("sweep%0d gap_pos", pops), 32'(gap_pos16), 32'(mp));
            check($sformatf("sweep%0d zeros", pops), $countones(~row16), 3);
            check($sformatf("sweep%0d runs", pops), zero_runs(row16), 1);
            check($sformatf("sweep%0d pos range", pops), 32'(gap_pos16 <= 4'd13), 1);
            pops++;
         end
      end
      check("sweep pop count", 32'(pops >= 50), 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule
